// File: rtl/ll_multi_ch_req_arb.sv
// Linked-list front end: round-robin arbitration over N_CH requesters, legality checks, wr/rd controller sequencing.
// Latency: accept->resp_vld 1 cycle for errors/RETURN_SIZE; otherwise 1 cycle after the controller completes.
// Backpressure: one request in flight; req_rdy stays low until the pending response is taken by its channel.
module ll_multi_ch_req_arb #(
    parameter int N_CH    = 4,
    parameter int PTR_WD  = 8,
    parameter int DATA_WD = 32,
    parameter int TMO_CYC = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_CH-1:0]           req_vld,
    input  logic [4*N_CH-1:0]         req_type,
    input  logic [PTR_WD*N_CH-1:0]    req_pos,
    input  logic [DATA_WD*N_CH-1:0]   req_data,
    output logic [N_CH-1:0]           req_rdy,
    output logic [N_CH-1:0]           resp_vld,
    input  logic [N_CH-1:0]           resp_taken,
    output logic [3:0]                resp_type,
    output logic [DATA_WD-1:0]        resp_data,
    output logic                      resp_data_vld,
    output logic [$clog2(N_CH)-1:0]   resp_ch,
    input  logic                      ll_empty,
    input  logic [PTR_WD-1:0]         ll_size,
    output logic                      wr_vld,
    output logic                      wr_insert,
    output logic [PTR_WD-1:0]         wr_pos,
    output logic [DATA_WD-1:0]        wr_data,
    input  logic                      wr_ready,
    output logic                      rd_vld,
    output logic                      rd_pop,
    output logic [PTR_WD-1:0]         rd_addr,
    input  logic                      rd_ready,
    input  logic                      rd_data_vld,
    input  logic [DATA_WD-1:0]        rd_data,
    output logic                      make_ll_empty,
    output logic                      busy
);

    localparam int CH_W = $clog2(N_CH);

    // Request types
    localparam logic [3:0] REQ_PUSH_HEAD   = 4'd0;
    localparam logic [3:0] REQ_PUSH_TAIL   = 4'd1;
    localparam logic [3:0] REQ_INSERT      = 4'd2;
    localparam logic [3:0] REQ_MODIFY      = 4'd3;
    localparam logic [3:0] REQ_READ_NODE   = 4'd4;
    localparam logic [3:0] REQ_DELETE_NODE = 4'd5;
    localparam logic [3:0] REQ_POP_HEAD    = 4'd6;
    localparam logic [3:0] REQ_POP_TAIL    = 4'd7;
    localparam logic [3:0] REQ_RETURN_SIZE = 4'd8;
    localparam logic [3:0] REQ_EMPTY_LL    = 4'd9;

    // Response types (0 = nothing pending)
    localparam logic [3:0] RSP_NONE      = 4'd0;
    localparam logic [3:0] RSP_OP_DONE   = 4'd1;
    localparam logic [3:0] RSP_RD_NODE   = 4'd2;
    localparam logic [3:0] RSP_DEL_NODE  = 4'd3;
    localparam logic [3:0] RSP_POP_HEAD  = 4'd4;
    localparam logic [3:0] RSP_POP_TAIL  = 4'd5;
    localparam logic [3:0] RSP_LL_SIZE   = 4'd6;
    localparam logic [3:0] RSP_ERROR     = 4'd7;

    // Error codes carried in resp_data when resp_type == RSP_ERROR
    localparam logic [3:0] ERR_NONE           = 4'd0;
    localparam logic [3:0] ERR_ILL_REQ_TYPE   = 4'd1;
    localparam logic [3:0] ERR_EMPTY_LL_EMPTY = 4'd2;
    localparam logic [3:0] ERR_POP_LL_EMPTY   = 4'd3;
    localparam logic [3:0] ERR_DEL_LL_EMPTY   = 4'd4;
    localparam logic [3:0] ERR_INS_LL_EMPTY   = 4'd5;
    localparam logic [3:0] ERR_POS_OOR        = 4'd6;
    localparam logic [3:0] ERR_TIMEOUT        = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_WAIT  = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_EMPTY    = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t state, state_nxt, cap_state;

    logic [3:0]         ch_type [N_CH];
    logic [PTR_WD-1:0]  ch_pos  [N_CH];
    logic [DATA_WD-1:0] ch_data [N_CH];

    logic [CH_W-1:0]    rr_ptr, gnt_idx, cand_idx, cur_ch;
    int                 cand;
    logic               gnt_found, arb_go;
    logic [3:0]         sel_type, cur_type, chk_err;
    logic [PTR_WD-1:0]  sel_pos;
    logic [DATA_WD-1:0] sel_data;
    logic               chk_hit;
    logic               wr_first;
    logic [7:0]         wd_cnt;
    logic               wd_tmo;
    logic               tmo_fire, done_fire, rd_fire;

    // Split the flat per-channel buses into indexable arrays
    for (genvar c = 0; c < N_CH; c++) begin : g_unpack
        assign ch_type[c] = req_type[c*4 +: 4];
        assign ch_pos[c]  = req_pos[c*PTR_WD +: PTR_WD];
        assign ch_data[c] = req_data[c*DATA_WD +: DATA_WD];
    end

    // Round-robin search: first valid channel at or after rr_ptr
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_CH) cand = cand - N_CH;
            cand_idx = CH_W'(cand);
            if (!gnt_found && req_vld[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    assign arb_go   = reset_n && (state == S_IDLE) && gnt_found;
    assign sel_type = ch_type[gnt_idx];
    assign sel_pos  = ch_pos[gnt_idx];
    assign sel_data = ch_data[gnt_idx];

    // One-hot accept strobe; suppressed while reset is held
    always_comb begin
        req_rdy = '0;
        if (arb_go) req_rdy[gnt_idx] = 1'b1;
    end

    // Legality checks on the granted request, first hit wins
    always_comb begin
        chk_err = ERR_NONE;
        if (sel_type > REQ_EMPTY_LL)
            chk_err = ERR_ILL_REQ_TYPE;
        else if (sel_type == REQ_EMPTY_LL && ll_empty)
            chk_err = ERR_EMPTY_LL_EMPTY;
        else if ((sel_type == REQ_POP_HEAD || sel_type == REQ_POP_TAIL) && ll_empty)
            chk_err = ERR_POP_LL_EMPTY;
        else if (sel_type == REQ_DELETE_NODE && ll_empty)
            chk_err = ERR_DEL_LL_EMPTY;
        else if (sel_type == REQ_INSERT && sel_pos != '0 && ll_empty)
            chk_err = ERR_INS_LL_EMPTY;
        else if (sel_type == REQ_INSERT && sel_pos > ll_size)
            chk_err = ERR_POS_OOR;
        else if ((sel_type == REQ_MODIFY || sel_type == REQ_READ_NODE ||
                  sel_type == REQ_DELETE_NODE) && sel_pos >= ll_size)
            chk_err = ERR_POS_OOR;
        chk_hit = (chk_err != ERR_NONE);
    end

    // Where a freshly accepted request goes
    always_comb begin
        cap_state = S_RESP;
        if (!chk_hit) begin
            case (sel_type)
                REQ_PUSH_HEAD, REQ_PUSH_TAIL,
                REQ_INSERT, REQ_MODIFY:          cap_state = S_WR_WAIT;
                REQ_READ_NODE, REQ_DELETE_NODE,
                REQ_POP_HEAD, REQ_POP_TAIL:      cap_state = S_RD_ISSUE;
                REQ_EMPTY_LL:                    cap_state = S_EMPTY;
                default:                         cap_state = S_RESP;
            endcase
        end
    end

    assign wd_tmo = (wd_cnt == 8'(TMO_CYC - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next state and command/response strobes
    always_comb begin
        state_nxt     = state;
        wr_vld        = 1'b0;
        rd_vld        = 1'b0;
        make_ll_empty = 1'b0;
        resp_vld      = '0;
        tmo_fire      = 1'b0;
        done_fire     = 1'b0;
        rd_fire       = 1'b0;
        busy          = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (arb_go) state_nxt = cap_state;
            end
            S_WR_WAIT: begin
                wr_vld = wr_first;
                if (!wr_first && wr_ready) begin
                    done_fire = 1'b1;
                    state_nxt = S_RESP;
                end else if (wd_tmo) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RD_ISSUE: begin
                if (rd_ready) begin
                    rd_vld    = 1'b1;
                    state_nxt = S_RD_WAIT;
                end else if (wd_tmo) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RD_WAIT: begin
                if (rd_data_vld) begin
                    rd_fire   = 1'b1;
                    state_nxt = S_RESP;
                end else if (wd_tmo) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_EMPTY: begin
                make_ll_empty = 1'b1;
                if (ll_empty) begin
                    done_fire = 1'b1;
                    state_nxt = S_RESP;
                end else if (wd_tmo) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_vld[cur_ch] = 1'b1;
                if (resp_taken[cur_ch]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the granted request and build controller commands
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            cur_ch    <= '0;
            cur_type  <= '0;
            wr_insert <= 1'b0;
            wr_pos    <= '0;
            wr_data   <= '0;
            rd_pop    <= 1'b0;
            rd_addr   <= '0;
        end else if (arb_go) begin
            rr_ptr    <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
            cur_ch    <= gnt_idx;
            cur_type  <= sel_type;
            wr_data   <= sel_data;
            wr_insert <= (sel_type != REQ_MODIFY);
            rd_pop    <= (sel_type == REQ_DELETE_NODE) || (sel_type == REQ_POP_HEAD) ||
                         (sel_type == REQ_POP_TAIL);
            case (sel_type)
                REQ_PUSH_HEAD: wr_pos <= '0;
                REQ_PUSH_TAIL: wr_pos <= ll_size;
                default:       wr_pos <= sel_pos;
            endcase
            case (sel_type)
                REQ_POP_HEAD: rd_addr <= '0;
                REQ_POP_TAIL: rd_addr <= ll_size - PTR_WD'(1);
                default:      rd_addr <= sel_pos;
            endcase
        end
    end

    // Pulse wr_vld only on the first WR_WAIT cycle; restart watchdog on every state change
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_first <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            wr_first <= (state != S_WR_WAIT) && (state_nxt == S_WR_WAIT);
            if (state_nxt != state)
                wd_cnt <= '0;
            else if (state == S_WR_WAIT || state == S_RD_ISSUE ||
                     state == S_RD_WAIT || state == S_EMPTY)
                wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // Response fields: loaded on the way into RESP, cleared once consumed
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_type     <= RSP_NONE;
            resp_data     <= '0;
            resp_data_vld <= 1'b0;
        end else if (arb_go && chk_hit) begin
            resp_type     <= RSP_ERROR;
            resp_data     <= DATA_WD'(chk_err);
            resp_data_vld <= 1'b1;
        end else if (arb_go && sel_type == REQ_RETURN_SIZE) begin
            resp_type     <= RSP_LL_SIZE;
            resp_data     <= DATA_WD'(ll_size);
            resp_data_vld <= 1'b1;
        end else if (tmo_fire) begin
            resp_type     <= RSP_ERROR;
            resp_data     <= DATA_WD'(ERR_TIMEOUT);
            resp_data_vld <= 1'b1;
        end else if (done_fire) begin
            resp_type     <= RSP_OP_DONE;
            resp_data     <= '0;
            resp_data_vld <= 1'b0;
        end else if (rd_fire) begin
            case (cur_type)
                REQ_DELETE_NODE: resp_type <= RSP_DEL_NODE;
                REQ_POP_HEAD:    resp_type <= RSP_POP_HEAD;
                REQ_POP_TAIL:    resp_type <= RSP_POP_TAIL;
                default:         resp_type <= RSP_RD_NODE;
            endcase
            resp_data     <= rd_data;
            resp_data_vld <= 1'b1;
        end else if (state == S_RESP && state_nxt == S_IDLE) begin
            resp_type     <= RSP_NONE;
            resp_data     <= '0;
            resp_data_vld <= 1'b0;
        end
    end

    assign resp_ch = cur_ch;

endmodule

// File: tb/tb_ll_multi_ch_req_arb.sv
// Directed bench for ll_multi_ch_req_arb: arbitration order, checks, wr/rd sequencing, watchdog, reset.
// Inputs driven 2 ns after the rising edge, outputs sampled 1 ns later.
// Every wait on the DUT is bounded; an expired bound shows up as a failed check.
module tb_ll_multi_ch_req_arb;

    localparam int N_CH = 4, PTR_WD = 8, DATA_WD = 32, TMO_CYC = 255;

    localparam logic [3:0] REQ_PUSH_TAIL = 4'd1, REQ_INSERT = 4'd2, REQ_MODIFY = 4'd3,
                           REQ_READ_NODE = 4'd4, REQ_DELETE_NODE = 4'd5, REQ_POP_HEAD = 4'd6,
                           REQ_POP_TAIL = 4'd7, REQ_RETURN_SIZE = 4'd8, REQ_EMPTY_LL = 4'd9;
    localparam logic [3:0] RSP_OP_DONE = 4'd1, RSP_RD_NODE = 4'd2, RSP_POP_TAIL = 4'd5,
                           RSP_LL_SIZE = 4'd6, RSP_ERROR = 4'd7;
    localparam int ERR_ILL = 1, ERR_EMPTY = 2, ERR_POP = 3, ERR_DEL = 4, ERR_INS = 5,
                   ERR_OOR = 6, ERR_TMO = 7;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [N_CH-1:0]         req_vld, req_rdy, resp_vld, resp_taken;
    logic [4*N_CH-1:0]       req_type;
    logic [PTR_WD*N_CH-1:0]  req_pos;
    logic [DATA_WD*N_CH-1:0] req_data;
    logic [3:0]              resp_type;
    logic [DATA_WD-1:0]      resp_data, wr_data, rd_data;
    logic                    resp_data_vld, ll_empty, wr_vld, wr_insert, wr_ready;
    logic [1:0]              resp_ch;
    logic [PTR_WD-1:0]       ll_size, wr_pos, rd_addr;
    logic                    rd_vld, rd_pop, rd_ready, rd_data_vld, make_ll_empty, busy;

    int n_chk = 0, n_pass = 0;
    int lat, cyc;

    always #5 clk = ~clk;

    ll_multi_ch_req_arb #(.N_CH(N_CH), .PTR_WD(PTR_WD), .DATA_WD(DATA_WD), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_vld(req_vld), .req_type(req_type), .req_pos(req_pos), .req_data(req_data),
        .req_rdy(req_rdy), .resp_vld(resp_vld), .resp_taken(resp_taken),
        .resp_type(resp_type), .resp_data(resp_data), .resp_data_vld(resp_data_vld),
        .resp_ch(resp_ch), .ll_empty(ll_empty), .ll_size(ll_size),
        .wr_vld(wr_vld), .wr_insert(wr_insert), .wr_pos(wr_pos), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_vld(rd_vld), .rd_pop(rd_pop), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_data_vld(rd_data_vld), .rd_data(rd_data),
        .make_ll_empty(make_ll_empty), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int ch, input logic [3:0] t, input logic [7:0] p, input logic [31:0] d);
        req_type[ch*4 +: 4]  = t;
        req_pos[ch*8 +: 8]   = p;
        req_data[ch*32 +: 32] = d;
        req_vld[ch]          = 1'b1;
    endtask

    // Wait for a grant, require it on exp_ch, let it be accepted, then drop that request
    task automatic do_accept(input int exp_ch, input string tag);
        logic [N_CH-1:0] g;
        int n;
        n = 0;
        #1;
        while (req_rdy == '0 && n < 50) begin
            tick();
            #1;
            n++;
        end
        g = req_rdy;
        check(tag, req_rdy, 64'(1 << exp_ch));
        tick();
        req_vld = req_vld & ~g;
    endtask

    // Wait for a response, compare all response fields, then consume it
    task automatic expect_resp(input int ch, input logic [3:0] typ, input logic [31:0] dat,
                               input logic dv, input string tag, output int l);
        l = 0;
        #1;
        while (resp_vld == '0 && l < 400) begin
            tick();
            #1;
            l++;
        end
        check({tag, "_vld"},  resp_vld, 64'(1 << ch));
        check({tag, "_ch"},   resp_ch, 64'(ch));
        check({tag, "_type"}, resp_type, typ);
        check({tag, "_data"}, resp_data, dat);
        check({tag, "_dvld"}, resp_data_vld, dv);
        resp_taken = 4'(1 << ch);
        tick();
        resp_taken = '0;
    endtask

    // Error vectors: channel, type, pos, empty, size, expected code
    int         e_ch  [7] = '{0, 1, 2, 3, 0, 1, 2};
    logic [3:0] e_typ [7] = '{REQ_READ_NODE, 4'd12, REQ_EMPTY_LL, REQ_DELETE_NODE,
                              REQ_INSERT, REQ_INSERT, REQ_POP_HEAD};
    logic [7:0] e_pos [7] = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd1, 8'd4, 8'd0};
    logic       e_emp [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] e_siz [7] = '{8'd7, 8'd3, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0};
    int         e_err [7] = '{ERR_OOR, ERR_ILL, ERR_EMPTY, ERR_DEL, ERR_INS, ERR_OOR, ERR_POP};

    initial begin
        reset_n = 1'b0; req_vld = '0; req_type = '0; req_pos = '0; req_data = '0;
        resp_taken = '0; ll_empty = 1'b0; ll_size = '0; wr_ready = 1'b0;
        rd_ready = 1'b0; rd_data_vld = 1'b0; rd_data = '0;
        repeat (3) tick();
        #1;
        check("rst_ctl", {req_rdy, resp_vld, wr_vld, rd_vld, make_ll_empty, busy,
                          resp_data_vld, resp_type, resp_ch, rd_pop, wr_insert}, 64'd0);
        check("rst_dat", {resp_data, rd_addr, wr_pos}, 64'd0);
        tick();
        reset_n = 1'b1;

        // All four channels ask for the size: served 0,1,2,3
        ll_size = 8'd5;
        for (int c = 0; c < 4; c++) set_req(c, REQ_RETURN_SIZE, 8'd0, 32'd0);
        for (int c = 0; c < 4; c++) begin
            do_accept(c, "rr_gnt");
            expect_resp(c, RSP_LL_SIZE, 32'd5, 1'b1, "size", lat);
            check("size_lat", lat, 0);
        end

        // PUSH_TAIL on ch2
        ll_size = 8'd3;
        set_req(2, REQ_PUSH_TAIL, 8'd0, 32'hA5);
        do_accept(2, "push_gnt");
        #1;
        check("push_cmd", {wr_vld, wr_insert, wr_pos, wr_data}, {1'b1, 1'b1, 8'd3, 32'hA5});
        tick();
        #1;
        check("push_pulse", wr_vld, 1'b0);
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        expect_resp(2, RSP_OP_DONE, 32'd0, 1'b0, "push", lat);

        // Legality errors; a read controller that is ready must never be issued to
        rd_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            ll_empty = e_emp[k];
            ll_size  = e_siz[k];
            set_req(e_ch[k], e_typ[k], e_pos[k], 32'd0);
            do_accept(e_ch[k], "err_gnt");
            #1;
            check("err_nocmd", {rd_vld, wr_vld}, 64'd0);
            expect_resp(e_ch[k], RSP_ERROR, 32'(e_err[k]), 1'b1, "err", lat);
            check("err_lat", lat, 0);
        end
        rd_ready = 1'b0;

        // READ_NODE pos 2 with size 7
        ll_empty = 1'b0;
        ll_size  = 8'd7;
        set_req(0, REQ_READ_NODE, 8'd2, 32'd0);
        do_accept(0, "rd_gnt");
        #1;
        check("rd_hold", rd_vld, 1'b0);
        rd_ready = 1'b1;
        #1;
        check("rd_cmd", {rd_vld, rd_pop, rd_addr}, {1'b1, 1'b0, 8'd2});
        tick();
        rd_ready = 1'b0;
        #1;
        check("rd_pulse", rd_vld, 1'b0);
        rd_data = 32'hDEADBEEF;
        rd_data_vld = 1'b1;
        tick();
        rd_data_vld = 1'b0;
        expect_resp(0, RSP_RD_NODE, 32'hDEADBEEF, 1'b1, "rd", lat);

        // POP_TAIL reads the last node and removes it
        rd_ready = 1'b1;
        set_req(3, REQ_POP_TAIL, 8'd0, 32'd0);
        do_accept(3, "pop_gnt");
        #1;
        check("pop_cmd", {rd_vld, rd_pop, rd_addr}, {1'b1, 1'b1, 8'd6});
        tick();
        rd_ready = 1'b0;
        rd_data = 32'h1234;
        rd_data_vld = 1'b1;
        tick();
        rd_data_vld = 1'b0;
        expect_resp(3, RSP_POP_TAIL, 32'h1234, 1'b1, "pop", lat);

        // EMPTY_LL on a non-empty list
        ll_size = 8'd4;
        set_req(2, REQ_EMPTY_LL, 8'd0, 32'd0);
        do_accept(2, "empty_gnt");
        #1;
        check("empty_on", {make_ll_empty, busy}, 2'b11);
        ll_empty = 1'b1;
        tick();
        expect_resp(2, RSP_OP_DONE, 32'd0, 1'b0, "empty", lat);
        #1;
        check("empty_off", make_ll_empty, 1'b0);
        ll_empty = 1'b0;

        // MODIFY with the write controller stuck: timeout TMO_CYC cycles after entry
        ll_size = 8'd5;
        set_req(1, REQ_MODIFY, 8'd1, 32'h55);
        do_accept(1, "mod_gnt");
        #1;
        check("mod_cmd", {wr_vld, wr_insert, wr_pos}, {1'b1, 1'b0, 8'd1});
        cyc = 0;
        while (cyc < 300) begin
            tick();
            cyc++;
            #1;
            if (resp_vld != '0) break;
        end
        check("tmo_cyc", cyc, TMO_CYC);
        expect_resp(1, RSP_ERROR, 32'(ERR_TMO), 1'b1, "tmo", lat);

        // Response held for 10 cycles; pending ch3 and a foreign resp_taken must not disturb it
        set_req(0, REQ_RETURN_SIZE, 8'd0, 32'd0);
        do_accept(0, "hold_gnt");
        set_req(3, REQ_RETURN_SIZE, 8'd0, 32'd0);
        resp_taken = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("hold", {resp_vld, req_rdy, resp_type, resp_data},
                  {4'b0001, 4'b0000, RSP_LL_SIZE, 32'd5});
            tick();
        end
        resp_taken = '0;
        expect_resp(0, RSP_LL_SIZE, 32'd5, 1'b1, "hold0", lat);
        do_accept(3, "hold_gnt3");
        expect_resp(3, RSP_LL_SIZE, 32'd5, 1'b1, "hold3", lat);

        // Reset in RD_WAIT: everything back to zero, RR pointer back to ch0
        rd_ready = 1'b1;
        set_req(1, REQ_READ_NODE, 8'd1, 32'd0);
        do_accept(1, "mid_gnt");
        tick();
        rd_ready = 1'b0;
        #1;
        check("mid_busy", {busy, rd_vld}, 2'b10);
        reset_n = 1'b0;
        set_req(0, REQ_RETURN_SIZE, 8'd0, 32'd0);
        set_req(2, REQ_RETURN_SIZE, 8'd0, 32'd0);
        tick();
        #1;
        check("mid_rst_ctl", {req_rdy, resp_vld, wr_vld, rd_vld, make_ll_empty, busy,
                              resp_data_vld, resp_type, resp_ch, rd_pop}, 64'd0);
        check("mid_rst_dat", {resp_data, rd_addr}, 64'd0);
        tick();
        reset_n = 1'b1;
        do_accept(0, "post_gnt0");
        expect_resp(0, RSP_LL_SIZE, 32'd5, 1'b1, "post0", lat);
        do_accept(2, "post_gnt2");
        expect_resp(2, RSP_LL_SIZE, 32'd5, 1'b1, "post2", lat);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
